// File: rtl/jt6295_pkg.sv
// rtl/jt6295_pkg.sv - shared state enum, request word and OKI command byte layout
package jt6295_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SETUP,
    S_LOW,
    S_HOLD,
    S_GAP
  } state_t;

  localparam int PLAY_BIT      = 7;
  localparam int STOP_MASK_LSB = 3;
  localparam int CH_MSB        = 7;
  localparam int ATT_LSB       = 0;

  typedef struct packed {
    logic       stop;
    logic [6:0] phrase;
    logic [3:0] mask;
    logic [3:0] att;
  } req_t;

  localparam int REQ_W = $bits(req_t);

  function automatic logic [7:0] play_byte(input logic [6:0] phrase);
    logic [7:0] b;
    b = '0;
    b[PLAY_BIT] = 1'b1;
    b[PLAY_BIT-1:0] = phrase;
    return b;
  endfunction

  // Bit 7 stays clear, which is what marks the byte as a stop
  function automatic logic [7:0] stop_byte(input logic [3:0] mask);
    logic [7:0] b;
    b = '0;
    b[STOP_MASK_LSB +: 4] = mask;
    return b;
  endfunction

  function automatic logic [7:0] att_byte(input logic [3:0] mask, input logic [3:0] att);
    logic [7:0] b;
    b = '0;
    b[CH_MSB -: 4] = mask;
    b[ATT_LSB +: 4] = att;
    return b;
  endfunction

endpackage

// File: rtl/jt6295_cmdfifo.sv
// rtl/jt6295_cmdfifo.sv - request FIFO; the head word comes straight from the storage flops
module jt6295_cmdfifo
  import jt6295_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic rst,
  input  logic clk,
  input  logic i_wr,
  input  req_t i_wdata,
  input  logic i_rd,
  output req_t o_rdata,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = $clog2(DEPTH);

  req_t          r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  logic          w_do_wr;
  logic          w_do_rd;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  // A read only ever sees a stored word, so a write into an empty FIFO is not visible this cycle
  assign w_do_rd = i_rd & ~o_empty;
  assign w_do_wr = i_wr & (~o_full | w_do_rd);
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_wr) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_do_rd) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_do_wr, w_do_rd})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/jt6295_cmdgen.sv
// rtl/jt6295_cmdgen.sv - queues play/stop requests and serialises them onto the JT6295 write port
module jt6295_cmdgen
  import jt6295_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int LOW_CYC   = 4,
  parameter int HOLD_CYC  = 2,
  parameter int GAP_CYC   = 8,
  parameter int WAIT_IDLE = 1,
  parameter int TMO_CYC   = 4096
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_stop,
  input  logic [6:0] req_phrase,
  input  logic [3:0] req_mask,
  input  logic [3:0] req_att,
  input  logic [3:0] busy,
  output logic [7:0] dout,
  output logic       wrn,
  output logic       pending,
  output logic       tmo,
  output logic       drop
);

  localparam int MAX_A = (LOW_CYC > HOLD_CYC) ? LOW_CYC : HOLD_CYC;
  localparam int MAX_B = (MAX_A > GAP_CYC) ? MAX_A : GAP_CYC;
  localparam int MAX_C = (MAX_B > TMO_CYC) ? MAX_B : TMO_CYC;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] C_LOW  = CW'(LOW_CYC - 1);
  localparam logic [CW-1:0] C_HOLD = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] C_GAP  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] C_TMO  = CW'(TMO_CYC - 1);
  localparam logic          P_WAIT = (WAIT_IDLE != 0);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_second;
  logic          w_second_nxt;
  req_t          r_req;
  req_t          w_req_nxt;
  logic [7:0]    r_dout;
  logic [7:0]    w_dout_nxt;
  logic          r_wrn;
  logic          r_tmo;
  logic          w_tmo_nxt;
  logic          r_drop;
  logic          r_rdy_en;
  logic          w_pop;
  logic          w_push;
  logic          w_full;
  logic          w_empty;
  req_t          w_in;
  req_t          w_head;

  assign w_in      = '{stop: req_stop, phrase: req_phrase, mask: req_mask, att: req_att};
  assign w_push    = req_valid & req_ready & (req_mask != 4'd0);
  assign req_ready = r_rdy_en & ~w_full;
  assign pending   = ~w_empty | (r_state != S_IDLE);
  assign dout      = r_dout;
  assign wrn       = r_wrn;
  assign tmo       = r_tmo;
  assign drop      = r_drop;

  jt6295_cmdfifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .rst     (rst),
    .clk     (clk),
    .i_wr    (w_push),
    .i_wdata (w_in),
    .i_rd    (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_second <= 1'b0;
      r_req    <= '0;
      r_dout   <= 8'h00;
      r_wrn    <= 1'b1;
      r_tmo    <= 1'b0;
      r_drop   <= 1'b0;
      r_rdy_en <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_second <= w_second_nxt;
      r_req    <= w_req_nxt;
      r_dout   <= w_dout_nxt;
      r_wrn    <= (w_state_nxt != S_LOW);
      r_tmo    <= w_tmo_nxt;
      r_drop   <= req_valid & req_ready & (req_mask == 4'd0);
      r_rdy_en <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_second_nxt = r_second;
    w_req_nxt    = r_req;
    w_dout_nxt   = r_dout;
    w_tmo_nxt    = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_req_nxt    = w_head;
          w_cnt_nxt    = '0;
          w_second_nxt = 1'b0;
          // Stops skip the busy check so a channel can always be silenced at once
          if (w_head.stop) begin
            w_dout_nxt  = stop_byte(w_head.mask);
            w_state_nxt = S_SETUP;
          end else if (P_WAIT && ((busy & w_head.mask) != 4'd0)) begin
            w_state_nxt = S_WAIT;
          end else begin
            w_dout_nxt  = play_byte(w_head.phrase);
            w_state_nxt = S_SETUP;
          end
        end
      end
      S_WAIT: begin
        if ((busy & r_req.mask) == 4'd0) begin
          w_dout_nxt  = play_byte(r_req.phrase);
          w_state_nxt = S_SETUP;
        end else if (r_cnt == C_TMO) begin
          w_tmo_nxt   = 1'b1;
          w_dout_nxt  = play_byte(r_req.phrase);
          w_state_nxt = S_SETUP;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_SETUP: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_LOW;
      end
      S_LOW: begin
        if (r_cnt == C_LOW) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_HOLD;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_HOLD: begin
        if (r_cnt == C_HOLD) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_GAP;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_GAP: begin
        if (r_cnt == C_GAP) begin
          w_cnt_nxt = '0;
          if (!r_req.stop && !r_second) begin
            w_second_nxt = 1'b1;
            w_dout_nxt   = att_byte(r_req.mask, r_req.att);
            w_state_nxt  = S_SETUP;
          end else begin
            w_second_nxt = 1'b0;
            w_state_nxt  = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_jt6295_cmdgen.sv
// tb/tb_jt6295_cmdgen.sv - directed bench for jt6295_cmdgen
module tb_jt6295_cmdgen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_stop = 1'b0;
  logic [6:0] req_phrase = '0;
  logic [3:0] req_mask = '0;
  logic [3:0] req_att = '0;
  logic [3:0] busy = '0;
  logic       req_ready, wrn, pending, tmo, drop;
  logic [7:0] dout;

  logic       req_valid2 = 1'b0;
  logic [3:0] busy2 = 4'hF;
  logic       req_ready2, wrn2, pending2, tmo2, drop2;
  logic [7:0] dout2;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic       wrn_q = 1'b1;
  logic       wrn2_q = 1'b1;
  int         low_run = 0;
  int         tmo_cnt = 0;
  int         fall_q[$];
  int         low_q[$];
  logic [7:0] byte_q[$];
  int         fall2_q[$];
  int         tmo2_q[$];
  logic [7:0] byte2_q[$];

  jt6295_cmdgen dut (
    .rst(rst), .clk(clk), .req_valid(req_valid), .req_ready(req_ready),
    .req_stop(req_stop), .req_phrase(req_phrase), .req_mask(req_mask), .req_att(req_att),
    .busy(busy), .dout(dout), .wrn(wrn), .pending(pending), .tmo(tmo), .drop(drop)
  );

  jt6295_cmdgen #(.TMO_CYC(64)) dut_t (
    .rst(rst), .clk(clk), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_stop(req_stop), .req_phrase(req_phrase), .req_mask(req_mask), .req_att(req_att),
    .busy(busy2), .dout(dout2), .wrn(wrn2), .pending(pending2), .tmo(tmo2), .drop(drop2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wrn_q && !wrn) fall_q.push_back(cyc);
    if (!wrn) low_run++;
    if (!wrn_q && wrn) begin
      byte_q.push_back(dout);
      low_q.push_back(low_run);
      low_run = 0;
    end
    if (tmo) tmo_cnt++;
    wrn_q = wrn;
    if (wrn2_q && !wrn2) fall2_q.push_back(cyc);
    if (!wrn2_q && wrn2) byte2_q.push_back(dout2);
    if (tmo2) tmo2_q.push_back(cyc);
    wrn2_q = wrn2;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    fall_q.delete(); low_q.delete(); byte_q.delete(); tmo_cnt = 0; low_run = 0;
    fall2_q.delete(); tmo2_q.delete(); byte2_q.delete();
  endtask

  function automatic logic [7:0] qb(input int i);
    return (i < byte_q.size()) ? byte_q[i] : 8'hxx;
  endfunction

  function automatic int qf(input int i);
    return (i < fall_q.size()) ? fall_q[i] : -1;
  endfunction

  task automatic push(input logic s, input logic [6:0] p, input logic [3:0] m, input logic [3:0] a);
    req_stop = s; req_phrase = p; req_mask = m; req_att = a;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    for (int k = 0; k < lim; k++) begin
      if (!pending) break;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_vec++; if (wrn !== 1'b1) begin n_err++; $display("FAIL rst_wrn: got %b want 1", wrn); end
    n_vec++; if (dout !== 8'h00) begin n_err++; $display("FAIL rst_dout: got %h want 00", dout); end
    n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", req_ready); end
    n_vec++; if (pending !== 1'b0) begin n_err++; $display("FAIL rst_pending: got %b want 0", pending); end
    n_vec++; if (tmo !== 1'b0) begin n_err++; $display("FAIL rst_tmo: got %b want 0", tmo); end
    n_vec++; if (drop !== 1'b0) begin n_err++; $display("FAIL rst_drop: got %b want 0", drop); end
    rst = 1'b0;
    tick();
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_after: got %b want 1", req_ready); end
  endtask

  task automatic test_play();
    int c0;
    clear_mon();
    busy = 4'h0;
    push(1'b0, 7'h15, 4'b0010, 4'd3);
    c0 = cyc;
    wait_idle(200);
    n_vec++; if (cyc - c0 !== 31) begin n_err++; $display("FAIL play_total: got %0d want 31", cyc - c0); end
    n_vec++; if (byte_q.size() !== 2) begin n_err++; $display("FAIL play_nbytes: got %0d want 2", byte_q.size()); end
    n_vec++; if (qb(0) !== 8'h95) begin n_err++; $display("FAIL play_b0: got %h want 95", qb(0)); end
    n_vec++; if (qb(1) !== 8'h23) begin n_err++; $display("FAIL play_b1: got %h want 23", qb(1)); end
    n_vec++; if (qf(0) - c0 !== 2) begin n_err++; $display("FAIL play_fall0: got %0d want 2", qf(0) - c0); end
    n_vec++; if (qf(1) - qf(0) !== 15) begin n_err++; $display("FAIL play_fall_gap: got %0d want 15", qf(1) - qf(0)); end
    n_vec++; if (low_q.size() != 2 || low_q[0] !== 4 || low_q[1] !== 4) begin
      n_err++; $display("FAIL play_low_len: got %0d entries, first %0d want 2 entries of 4",
                        low_q.size(), (low_q.size() > 0) ? low_q[0] : -1);
    end
  endtask

  task automatic test_stop_busy();
    int c0;
    clear_mon();
    busy = 4'b1111;
    push(1'b1, 7'h00, 4'b1001, 4'd0);
    c0 = cyc;
    wait_idle(200);
    busy = 4'h0;
    n_vec++; if (byte_q.size() !== 1) begin n_err++; $display("FAIL stop_nbytes: got %0d want 1", byte_q.size()); end
    n_vec++; if (qb(0) !== 8'h48) begin n_err++; $display("FAIL stop_b0: got %h want 48", qb(0)); end
    n_vec++; if (qf(0) - c0 !== 2) begin n_err++; $display("FAIL stop_fall0: got %0d want 2", qf(0) - c0); end
    n_vec++; if (cyc - c0 !== 16) begin n_err++; $display("FAIL stop_total: got %0d want 16", cyc - c0); end
  endtask

  task automatic test_wait_release();
    int crel;
    clear_mon();
    busy = 4'b0001;
    push(1'b0, 7'h2A, 4'b0001, 4'd5);
    repeat (100) tick();
    n_vec++; if (fall_q.size() !== 0) begin n_err++; $display("FAIL wait_early_write: got %0d falls want 0", fall_q.size()); end
    n_vec++; if (pending !== 1'b1) begin n_err++; $display("FAIL wait_pending: got %b want 1", pending); end
    busy = 4'b0000;
    crel = cyc;
    wait_idle(200);
    n_vec++; if (qf(0) - crel !== 2) begin n_err++; $display("FAIL wait_fall: got %0d want 2", qf(0) - crel); end
    n_vec++; if (qb(0) !== 8'hAA) begin n_err++; $display("FAIL wait_b0: got %h want AA", qb(0)); end
    n_vec++; if (qb(1) !== 8'h15) begin n_err++; $display("FAIL wait_b1: got %h want 15", qb(1)); end
    n_vec++; if (tmo_cnt !== 0) begin n_err++; $display("FAIL wait_tmo: got %0d pulses want 0", tmo_cnt); end
  endtask

  task automatic test_timeout();
    int c0;
    clear_mon();
    req_stop = 1'b0; req_phrase = 7'h33; req_mask = 4'b0100; req_att = 4'd0;
    req_valid2 = 1'b1;
    tick();
    req_valid2 = 1'b0;
    c0 = cyc;
    for (int k = 0; k < 300; k++) begin
      if (!pending2) break;
      tick();
    end
    n_vec++; if (pending2 !== 1'b0) begin n_err++; $display("FAIL tmo_done: got pending %b want 0", pending2); end
    n_vec++; if (tmo2_q.size() !== 1) begin n_err++; $display("FAIL tmo_pulses: got %0d want 1", tmo2_q.size()); end
    n_vec++; if (tmo2_q.size() == 0 || tmo2_q[0] - c0 !== 65) begin
      n_err++; $display("FAIL tmo_when: got %0d want 65", (tmo2_q.size() > 0) ? tmo2_q[0] - c0 : -1);
    end
    n_vec++; if (fall2_q.size() == 0 || fall2_q[0] - c0 !== 66) begin
      n_err++; $display("FAIL tmo_fall: got %0d want 66", (fall2_q.size() > 0) ? fall2_q[0] - c0 : -1);
    end
    n_vec++; if (byte2_q.size() != 2 || byte2_q[0] !== 8'hB3 || byte2_q[1] !== 8'h40) begin
      n_err++; $display("FAIL tmo_bytes: got %0d bytes, first %h want B3 40", byte2_q.size(),
                        (byte2_q.size() > 0) ? byte2_q[0] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    logic       s_t [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [6:0] p_t [5] = '{7'h01, 7'h00, 7'h7F, 7'h00, 7'h40};
    logic [3:0] m_t [5] = '{4'b0001, 4'b0010, 4'b1000, 4'b1111, 4'b0100};
    logic [3:0] a_t [5] = '{4'h0, 4'h0, 4'hF, 4'h0, 4'h7};
    logic [7:0] exp_b [9] = '{8'h08, 8'h81, 8'h10, 8'h10, 8'hFF, 8'h8F, 8'h78, 8'hC0, 8'h47};
    logic       exp_r [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       rdy;
    clear_mon();
    push(1'b1, 7'h00, 4'b0001, 4'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      req_stop = s_t[i]; req_phrase = p_t[i]; req_mask = m_t[i]; req_att = a_t[i];
      req_valid = 1'b1;
      rdy = req_ready;
      n_vec++; if (rdy !== exp_r[i]) begin n_err++; $display("FAIL b2b_ready%0d: got %b want %b", i, rdy, exp_r[i]); end
      for (int k = 0; k < 200 && !req_ready; k++) tick();
      tick();
      if (i == 3) begin
        n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full: got %b want 0", req_ready); end
      end
    end
    req_valid = 1'b0;
    wait_idle(800);
    n_vec++; if (byte_q.size() !== 9) begin n_err++; $display("FAIL b2b_nbytes: got %0d want 9", byte_q.size()); end
    for (int i = 0; i < 9; i++) begin
      n_vec++; if (qb(i) !== exp_b[i]) begin n_err++; $display("FAIL b2b_byte%0d: got %h want %h", i, qb(i), exp_b[i]); end
    end
  endtask

  task automatic test_drop();
    clear_mon();
    push(1'b0, 7'h11, 4'b0000, 4'd2);
    n_vec++; if (drop !== 1'b1) begin n_err++; $display("FAIL drop_play: got %b want 1", drop); end
    n_vec++; if (pending !== 1'b0) begin n_err++; $display("FAIL drop_pending: got %b want 0", pending); end
    tick();
    n_vec++; if (drop !== 1'b0) begin n_err++; $display("FAIL drop_pulse_len: got %b want 0", drop); end
    push(1'b1, 7'h00, 4'b0000, 4'd0);
    n_vec++; if (drop !== 1'b1) begin n_err++; $display("FAIL drop_stop: got %b want 1", drop); end
    repeat (30) tick();
    n_vec++; if (fall_q.size() !== 0) begin n_err++; $display("FAIL drop_writes: got %0d falls want 0", fall_q.size()); end
  endtask

  task automatic test_reset_mid_write();
    clear_mon();
    push(1'b0, 7'h05, 4'b0011, 4'd1);
    for (int k = 0; k < 20 && wrn !== 1'b0; k++) tick();
    n_vec++; if (wrn !== 1'b0) begin n_err++; $display("FAIL rmw_low: got %b want 0", wrn); end
    rst = 1'b1;
    tick();
    n_vec++; if (wrn !== 1'b1) begin n_err++; $display("FAIL rmw_wrn: got %b want 1", wrn); end
    n_vec++; if (dout !== 8'h00) begin n_err++; $display("FAIL rmw_dout: got %h want 00", dout); end
    rst = 1'b0;
    tick();
    clear_mon();
    repeat (60) tick();
    n_vec++; if (fall_q.size() !== 0) begin n_err++; $display("FAIL rmw_more_writes: got %0d want 0", fall_q.size()); end
    n_vec++; if (pending !== 1'b0) begin n_err++; $display("FAIL rmw_pending: got %b want 0", pending); end
  endtask

  initial begin
    test_reset();
    test_play();
    test_stop_busy();
    test_wait_release();
    test_timeout();
    test_back_to_back();
    test_drop();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jt6295_cmdgen.md
Name: jt6295_cmdgen

Overview:
- Host-side command issuer for the JT6295 CPU write port.
- Accepts play and stop requests on a valid/ready interface and buffers them in a small FIFO.
- Serialises each request into the OKI byte protocol: play is two writes, {1,phrase} then {ch_mask,att}; stop is one write, {0,ch_mask,000}.
- Drives dout/wrn with programmable setup, low, hold and gap timing. Used by test harnesses and by cores that replace the sound CPU.

Parameters:
- DEPTH, 4, request FIFO entries; power of two, 2..16.
- LOW_CYC, 4, clk cycles wrn is held low per write; ≥1.
- HOLD_CYC, 2, clk cycles dout stays stable after the wrn rising edge; ≥1.
- GAP_CYC, 8, clk cycles with wrn high between consecutive writes; ≥1.
- WAIT_IDLE, 1, 1 = a play waits until its target channels are not busy.
- TMO_CYC, 4096, maximum wait cycles in WAIT before the play is issued anyway.

Ports:
- rst  in  1  synchronous reset, active-high.
- clk  in  1  clock.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO not full.
- req_stop  in  1  1 = stop request, 0 = play request.
- req_phrase  in  7  phrase number; ignored for stop.
- req_mask  in  4  channel mask, bit n = channel n.
- req_att  in  4  attenuation code; ignored for stop.
- busy  in  4  channel busy status from the sound chip.
- dout  out  8  data bus to the chip din.
- wrn  out  1  write strobe; active low, latched by the chip on the rising edge.
- pending  out  1  FIFO non-empty or sequencer not in IDLE.
- tmo  out  1  one-cycle pulse when a WAIT times out.
- drop  out  1  one-cycle pulse when a request with req_mask==0 is discarded.

Behaviour:
- Reset: wrn=1, dout=8'h00, req_ready=0 for the reset cycle, then 1. pending=0, tmo=0, drop=0. FIFO emptied, state IDLE.
- Reset mid-write:
  - wrn returns high with dout=00 in the same cycle.
  - If the chip sees this edge, 00 decodes as stop-none, or as ch=0 with no channels started. Either way it is harmless.
- Enqueue:
  - Happens on req_valid & req_ready.
  - req_mask==0 is not stored; drop pulses on the next cycle.
  - req_ready=0 when DEPTH entries are held. Enqueue and dequeue in the same cycle are legal when full and when empty (no bypass: dequeue sees only the stored entry).
- FSM states: IDLE, WAIT, SETUP, LOW, HOLD, GAP. Counter cnt; flag second (second byte of a play).
- IDLE:
  - FIFO non-empty → pop the head.
  - Stop request → dout={0,mask,3'b000}, go to SETUP.
  - Play request with WAIT_IDLE=1 and (busy&mask)!=0 → go to WAIT.
  - Otherwise dout={1,phrase}, go to SETUP.
- WAIT:
  - Stays until (busy&mask)==0 or cnt reaches TMO_CYC.
  - On timeout, tmo pulses one cycle.
  - Exits to SETUP with dout={1,phrase}.
- SETUP: one cycle, dout stable, wrn=1. Then wrn=0, go to LOW.
- LOW: wrn=0 for exactly LOW_CYC cycles, then wrn=1 and go to HOLD.
- HOLD:
  - dout unchanged for HOLD_CYC cycles after the rising edge.
  - Then go to GAP; dout is held, not cleared.
- GAP: wrn=1 for GAP_CYC cycles, then:
  - If the current request is a play and second=0 → second=1, dout={mask,att}, go to SETUP.
  - Otherwise → second=0, go to IDLE.
- The two play bytes are never interleaved with another request.
- Throughput:
  - One byte costs 1+LOW_CYC+HOLD_CYC+GAP_CYC cycles (15 with defaults).
  - A play costs 2× that plus one IDLE cycle.
- busy is sampled only in IDLE and WAIT. A stop is never delayed by busy.
- Counters are sized for max(LOW_CYC, HOLD_CYC, GAP_CYC, TMO_CYC).

Decomposition:
- Shared package jt6295_pkg holds:
  - the state enum;
  - the command byte field positions: PLAY_BIT=7, STOP_MASK_LSB=3, CH_MSB=7, ATT_LSB=0;
  - the request struct {stop, phrase, mask, att} (16 bits).
- Sub-module jt6295_cmdfifo: synchronous FIFO of 16-bit request words, with full/empty and registered output.

Test Plan:
- Play phrase 0x15, mask 4'b0010, att 3, busy=0 → writes 0x95 then 0x23. Each write has wrn low 4 cycles. Falling edges are 15 cycles apart; total 31 cycles from req to IDLE.
- Stop mask 4'b1001 while busy=4'b1111 → a single write of 0x48 issued immediately; no WAIT.
- Play mask 4'b0001 with busy[0]=1, released after 100 cycles → no write before the release. The first wrn falls 2 cycles after busy[0]=0. tmo stays 0.
- Same play with busy stuck at 1, TMO_CYC=64 → tmo pulses at cycle 64, then 0x80|phrase is written.
- Push 5 requests back-to-back with DEPTH=4 → req_ready low after the 4th. All 5 are eventually written in order; no byte is lost or duplicated. drop is tested separately with mask=0 and must not write.
- Assert rst during LOW of a play's first byte → wrn=1 and dout=00 on the next cycle. No further writes occur, and pending=0.
